// File: rtl/fan_pkg.sv
// Shared types and constants for the fan reduction datapath.
package fan_pkg;

   localparam int unsigned FP_W = 32;

   typedef logic [FP_W-1:0] fp32_t;

   localparam fp32_t FP_ONE  = 32'h3F80_0000;
   localparam fp32_t FP_TWO  = 32'h4000_0000;
   localparam fp32_t FP_QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/fp32adder.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even,
// gradual underflow, quiet-NaN on invalid operations.
module fp32adder
   import fan_pkg::*;
(
   input  logic [FP_W-1:0] a_i,
   input  logic [FP_W-1:0] b_i,
   output logic [FP_W-1:0] y_o
);

   logic [31:0] x, y;
   logic [7:0]  ex, ey, d;
   logic [26:0] ax, ay, mask;
   logic [27:0] s;
   logic [26:0] m;
   logic [9:0]  e;
   logic [24:0] mr;
   logic        sub, rup, x_nan, y_nan;

   // align, add/subtract, normalise, round and pack
   always_comb begin
      // x is the operand with the larger magnitude
      x = a_i;
      y = b_i;
      if (b_i[30:0] > a_i[30:0]) begin
         x = b_i;
         y = a_i;
      end
      ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
      ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
      d  = ex - ey;
      ax = {x[30:23] != 8'd0, x[22:0], 3'b000};
      ay = {y[30:23] != 8'd0, y[22:0], 3'b000};
      mask = '0;
      // bits shifted out of the smaller operand collapse into a sticky bit
      if (d >= 8'd27) begin
         ay = {26'd0, |ay};
      end else begin
         mask = (27'd1 << d) - 27'd1;
         ay   = (ay >> d) | {26'd0, |(ay & mask)};
      end
      sub = x[31] ^ y[31];
      s   = sub ? ({1'b0, ax} - {1'b0, ay}) : ({1'b0, ax} + {1'b0, ay});
      e   = {2'b00, ex};
      if (s[27]) begin
         m = s[27:1] | {26'd0, s[0]};
         e = e + 10'd1;
      end else begin
         m = s[26:0];
         // left-normalise, stopping at the denormal exponent
         for (int unsigned i = 0; i < 26; i++) begin
            if (!m[26] && (e > 10'd1)) begin
               m = m << 1;
               e = e - 10'd1;
            end
         end
      end
      rup = m[2] & (m[1] | m[0] | m[3]);
      mr  = {1'b0, m[26:3]} + {24'd0, rup};
      if (mr[24]) begin
         mr = mr >> 1;
         e  = e + 10'd1;
      end
      x_nan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
      y_nan = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
      if (x_nan || y_nan) begin
         y_o = FP_QNAN;
      end else if (x[30:23] == 8'hFF) begin
         y_o = ((y[30:23] == 8'hFF) && sub) ? FP_QNAN : x;
      end else if (s == '0) begin
         y_o = {x[31] & y[31], 31'd0};
      end else if (e >= 10'd255) begin
         y_o = {x[31], 8'hFF, 23'd0};
      end else begin
         y_o = {x[31], (mr[23] ? e[7:0] : 8'd0), mr[22:0]};
      end
   end

endmodule

// File: rtl/rr_arb.sv
// Combinational round-robin grant: first valid index at or above ptr_i,
// wrapping from NREQ-1 to 0.
module rr_arb #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_valid_i,
   input  logic [IDW-1:0]  ptr_i,
   output logic [NREQ-1:0] grant_o,
   output logic [IDW-1:0]  g_o
);

   logic           found;
   logic [IDW-1:0] idx;

   // circular priority search starting at the pointer
   always_comb begin
      found   = 1'b0;
      idx     = '0;
      g_o     = '0;
      grant_o = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = IDW'((32'(ptr_i) + k) % NREQ);
         if (!found && req_valid_i[idx]) begin
            found = 1'b1;
            g_o   = idx;
         end
      end
      grant_o[g_o] = found;
   end

endmodule

// File: rtl/fan_add_arbiter.sv
// Shares a single fp32adder among NREQ requesters with round-robin
// arbitration and a one-entry registered result stage.
module fan_add_arbiter
   import fan_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*FP_W-1:0] req_a,
   input  logic [NREQ*FP_W-1:0] req_b,
   input  logic [NREQ-1:0]      req_add,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [FP_W-1:0]      rsp_data,
   output logic [IDW-1:0]       rsp_id
);

   logic [IDW-1:0]  ptr_q, ptr_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [FP_W-1:0] rsp_data_q, rsp_data_d;
   logic [IDW-1:0]  rsp_id_q, rsp_id_d;

   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  g;
   logic            load_ok, any_valid, fire;
   logic [FP_W-1:0] a_arr [NREQ];
   logic [FP_W-1:0] b_arr [NREQ];
   logic [FP_W-1:0] op_a, op_b, sum, result;

   rr_arb #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr_arb (
      .req_valid_i (req_valid),
      .ptr_i       (ptr_q),
      .grant_o     (grant),
      .g_o         (g)
   );

   // unpack operand buses and select the granted requester's operands
   always_comb begin
      for (int unsigned i = 0; i < NREQ; i++) begin
         a_arr[i] = req_a[i*FP_W +: FP_W];
         b_arr[i] = req_b[i*FP_W +: FP_W];
      end
      op_a = a_arr[g];
      op_b = b_arr[g];
   end

   fp32adder u_fp32adder (
      .a_i (op_a),
      .b_i (op_b),
      .y_o (sum)
   );

   // handshake: accept whenever the result slot is free or draining
   always_comb begin
      load_ok   = !rsp_valid_q || rsp_ready;
      any_valid = |req_valid;
      fire      = load_ok && any_valid;
      req_ready = fire ? grant : '0;
      result    = req_add[g] ? sum : op_a;
   end

   // next-state for the result register and round-robin pointer
   always_comb begin
      ptr_d       = ptr_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_id_d    = rsp_id_q;
      if (fire) begin
         rsp_valid_d = 1'b1;
         rsp_data_d  = result;
         rsp_id_d    = g;
         ptr_d       = (32'(g) == NREQ - 1) ? '0 : g + IDW'(1);
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   // state registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= '0;
      end else begin
         ptr_q       <= ptr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_id_q    <= rsp_id_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;

endmodule
